// File: rtl/dbus_mem_ctrl_pkg.sv
// Shared types for the data-bus side of the core: size codes, controller states,
// and the dbus request/response bundles also used by the fetch path.
package dbus_mem_ctrl_pkg;

  localparam int DBUS_XLEN = 64;
  localparam int DBUS_STRB = DBUS_XLEN / 8;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic [DBUS_XLEN-1:0] addr;
    logic [2:0]           size;
    logic [DBUS_STRB-1:0] strobe;
    logic [DBUS_XLEN-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic                 addr_ok;
    logic                 data_ok;
    logic [DBUS_XLEN-1:0] data;
  } dbus_resp_t;

  function automatic logic [7:0] size_mask(input size_e sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [2:0] lo);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return lo[0];
      SZ_W:    return |lo[1:0];
      default: return |lo;
    endcase
  endfunction

endpackage

// File: rtl/dbus_mem_ctrl_mem_fmt.sv
// Combinational byte-lane alignment for stores and shift/extend for loads.
// Kept free of state so a cache-side path can reuse it as-is.
module mem_fmt
  import dbus_mem_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  size_e            size,
  input  logic             uns,
  input  logic [2:0]       addr_lo,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rword,
  output logic [7:0]       strobe,
  output logic [XLEN-1:0]  sdata,
  output logic [XLEN-1:0]  ldata
);

  logic [5:0]      bsh;
  logic [XLEN-1:0] sh;

  assign bsh    = {addr_lo, 3'b000};
  assign strobe = size_mask(size) << addr_lo;
  assign sdata  = wdata << bsh;
  assign sh     = rword >> bsh;

  always_comb begin
    ldata = sh;
    case (size)
      SZ_B:    ldata = {{(XLEN-8){~uns & sh[7]}},   sh[7:0]};
      SZ_H:    ldata = {{(XLEN-16){~uns & sh[15]}}, sh[15:0]};
      SZ_W:    ldata = {{(XLEN-32){~uns & sh[31]}}, sh[31:0]};
      default: ldata = sh;
    endcase
  end

endmodule

// File: rtl/dbus_mem_ctrl.sv
// M-stage data-bus controller: issues load/store requests, holds them until
// data_ok, formats load data and buffers it while the pipeline is frozen.
module dbus_mem_ctrl
  import dbus_mem_ctrl_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m_valid,
  input  logic             m_load,
  input  logic             m_store,
  input  logic [2:0]       m_funct3,
  input  logic [XLEN-1:0]  m_addr,
  input  logic [XLEN-1:0]  m_wdata,
  input  logic             m_advance,
  output logic             dreq_valid,
  output logic [XLEN-1:0]  dreq_addr,
  output logic [2:0]       dreq_size,
  output logic [7:0]       dreq_strobe,
  output logic [XLEN-1:0]  dreq_data,
  input  logic             dresp_addr_ok,
  input  logic             dresp_data_ok,
  input  logic [XLEN-1:0]  dresp_data,
  output logic             d_wait,
  output logic [XLEN-1:0]  rdata,
  output logic             misalign,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e          state, state_nx;
  dbus_req_t       m_req, r_req, req;
  dbus_resp_t      resp;
  logic            r_uns;
  logic [XLEN-1:0] r_rdata, ldata, f_sdata;
  logic [7:0]      f_strobe;
  size_e           f_size;
  logic            f_uns;
  logic [2:0]      f_alo;
  logic            memop, idle, lat_req, lat_rdata;
  logic            unused_resp;

  assign resp        = '{addr_ok: dresp_addr_ok, data_ok: dresp_data_ok, data: dresp_data};
  assign unused_resp = resp.addr_ok;

  assign memop    = m_valid & (m_load | m_store);
  assign misalign = memop & is_misaligned(size_e'(m_funct3[1:0]), m_addr[2:0]);
  assign idle     = (state == ST_IDLE);

  // Live M fields drive formatting in IDLE; captured fields once the request is held.
  assign f_size = idle ? size_e'(m_funct3[1:0]) : size_e'(r_req.size[1:0]);
  assign f_uns  = idle ? m_funct3[2] : r_uns;
  assign f_alo  = idle ? m_addr[2:0] : r_req.addr[2:0];

  mem_fmt #(.XLEN(XLEN)) u_fmt (
    .size    (f_size),
    .uns     (f_uns),
    .addr_lo (f_alo),
    .wdata   (m_wdata),
    .rword   (resp.data),
    .strobe  (f_strobe),
    .sdata   (f_sdata),
    .ldata   (ldata)
  );

  always_comb begin
    m_req        = '0;
    m_req.valid  = memop & ~misalign;
    m_req.addr   = m_addr;
    m_req.size   = {1'b0, m_funct3[1:0]};
    m_req.strobe = m_store ? f_strobe : 8'h00;
    m_req.data   = m_store ? f_sdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req       = '0;
    d_wait    = 1'b0;
    rdata     = '0;
    lat_req   = 1'b0;
    lat_rdata = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req    = m_req;
        d_wait = m_req.valid & ~resp.data_ok;
        if (m_req.valid & resp.data_ok) rdata = ldata;
        if (m_req.valid & ~resp.data_ok) begin
          lat_req  = 1'b1;
          state_nx = ST_REQ;
        end else if (m_req.valid & ~m_advance) begin
          lat_rdata = 1'b1;
          state_nx  = ST_DONE;
        end
      end
      ST_REQ: begin
        req    = r_req;
        d_wait = ~resp.data_ok;
        if (resp.data_ok) begin
          rdata     = ldata;
          lat_rdata = 1'b1;
          state_nx  = m_advance ? ST_IDLE : ST_DONE;
        end
      end
      ST_DONE: begin
        // Response already consumed; bus strobes here belong to nobody.
        rdata = r_rdata;
        if (m_advance) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_req     <= '0;
      r_uns     <= 1'b0;
      r_rdata   <= '0;
      stall_cnt <= '0;
    end else begin
      if (lat_req) begin
        r_req <= m_req;
        r_uns <= m_funct3[2];
      end
      if (lat_rdata) r_rdata <= ldata;
      if (d_wait && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign dreq_valid  = req.valid;
  assign dreq_addr   = req.addr;
  assign dreq_size   = req.size;
  assign dreq_strobe = req.strobe;
  assign dreq_data   = req.data;

  always_ff @(posedge clk) begin
    if (reset) assert (!(m_advance && d_wait)) else $error("m_advance asserted while d_wait");
  end

endmodule
